loxodes_sequence_monitor: RTL
=============================

Name: loxodes_sequence_monitor

Overview:
Receive-side checker for the 8-channel thermometer power-up/power-down sequencer output. Samples the 8 channel lines and decodes the active level (0..8). Recovers the per-step delay setting and classifies the ramp direction. Flags any non-thermometer pattern or any jump of more than one level as a sticky fault. Sits on the board/bench side of the sequencer outputs, or as an on-chip self-check in the same clock domain.

Parameters:
None; all widths are fixed. Level is 4 bits (0..8). Delay is 5 bits, matching the sequencer's delay input.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset; all state clears while low
channel_in  input  8  channel lines; bit0 is the first channel on
clear  input  1  synchronous fault/measurement clear, active-high
level  output  4  current decoded level, 0..8
measured_delay  output  5  idle cycles between the last two accepted steps, saturating at 31
step  output  1  one-cycle pulse on each accepted level change
dir  output  1  1 = last accepted step was up, 0 = down
fault  output  1  sticky error flag
state  output  3  0 IDLE, 1 UP, 2 DOWN, 3 FULL, 4 FAULT

Behaviour:
- Reset (reset=0, async): sync flops, level, measured_delay, counter, step, dir and fault all = 0; state = IDLE.
- Input synchroniser: 2-flop sync of channel_in giving s1 then s2. Decode is combinational from s2.
- Latency: a channel_in change captured at edge E0 appears on level/step after edge E2.
- Decode: s2 is valid iff it equals (1<<k)-1 for some k in 0..8; k is the decoded level.
- Internal counter, 5 bits: cleared on every accepted step; otherwise increments each cycle, saturating at 31.
- Per-cycle rules when clear=0 and state != FAULT:
  - valid and k == level: no step; counter advances.
  - valid and k == level+1: step=1, dir=1, level=k, measured_delay=counter, counter=0.
  - valid and k == level-1: step=1, dir=0, level=k, measured_delay=counter, counter=0.
  - invalid code, or valid with |k-level| > 1: fault=1, state=FAULT. Level, dir and measured_delay are frozen and step=0.
- Delay mapping: a sequencer with delay D spaces steps D+1 cycles apart, so measured_delay = D (exact for D ≤ 30; D=31 also reads 31).
- The first step out of a long hold reports 31 (saturated). This is expected.
- State transitions, taken after an accepted step:
  - level=0 → IDLE
  - level=8 → FULL
  - otherwise UP if dir=1, DOWN if dir=0
- FAULT is absorbing until clear or reset. While in FAULT the counter keeps running; all other registers hold.
- clear=1 (sync) has priority over every rule above in the same cycle:
  - fault=0, counter=0, measured_delay=0, step=0, dir=0.
  - level = k if s2 is valid, else 0.
  - state derived from the new level: 0 → IDLE, 8 → FULL, else UP.
- A fault-causing code arriving in the same cycle as clear is ignored for that cycle. It is re-evaluated on the next cycle if still present.
- step is high for exactly one cycle per accepted step; two consecutive accepted steps give two separate pulses.
- Reset asserted mid-ramp returns everything to the reset values immediately, independent of clk.

Test Plan:
- Ramp up, D=3: channel_in 0x00→0x01→0x03…→0xFF, one step every 4 cycles → level 1..8, 8 step pulses, dir=1, measured_delay=3 from the 2nd step on, final state FULL, fault=0.
- Ramp down from 0xFF, D=5, shifting right every 6 cycles → level 7..0, dir=0, measured_delay=5, state DOWN then IDLE, fault=0.
- Invalid code: at level 2 (0x03), drive 0x05 → fault=1 and state=FAULT two edges after the sample. Level stays 2. A later 0x07 gives no step. Pulse clear with 0x07 held → fault=0, level=3, state=UP.
- Level jump: at 0x03, drive 0x0F → fault=1, level stays 2. Clear with 0x0F → level=4, state=UP.
- Saturation: hold 0x0F for 50 cycles, then drive 0x1F → step=1, level=5, measured_delay=31.
- Async reset: mid up-ramp at level 5, drive reset=0 between clock edges → all outputs 0 and state IDLE immediately. After release with 0xFF held → fault=1 (0→8 is a jump), state FAULT.

Source files
------------

// File: rtl/loxodes_sequence_monitor.sv
// Receive-side checker for an 8-channel thermometer sequencer: decodes the active
// level, measures the per-step delay, tracks ramp direction and latches faults.
module loxodes_sequence_monitor (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] channel_in,
  input  logic       clear,
  output logic [3:0] level,
  output logic [4:0] measured_delay,
  output logic       step,
  output logic       dir,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_UP    = 3'd1,
    ST_DOWN  = 3'd2,
    ST_FULL  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] s1_reg, s2_reg;
  logic [3:0] level_reg, level_next;
  logic [4:0] delay_reg, delay_next;
  logic [4:0] cnt_reg, cnt_next;
  logic       step_reg, step_next;
  logic       dir_reg, dir_next;
  logic       fault_reg, fault_next;

  logic [8:0] code_match;
  logic       code_valid;
  logic [3:0] code_level;
  logic       is_up, is_down, is_hold;
  logic [4:0] cnt_inc;

  // One comparator per legal thermometer code (1<<gi)-1.
  generate
    for (genvar gi = 0; gi <= 8; gi++) begin : g_decode
      localparam logic [8:0] THERM = (9'd1 << gi) - 9'd1;
      assign code_match[gi] = (s2_reg == THERM[7:0]);
    end
  endgenerate

  assign code_valid = |code_match;

  always_comb begin
    code_level = 4'd0;
    for (int i = 0; i <= 8; i++) begin
      if (code_match[i]) code_level = 4'(i);
    end
  end

  assign is_up   = code_valid && (code_level == level_reg + 4'd1);
  assign is_down = code_valid && (level_reg != 4'd0) && (code_level == level_reg - 4'd1);
  assign is_hold = code_valid && (code_level == level_reg);
  assign cnt_inc = (cnt_reg == 5'd31) ? cnt_reg : cnt_reg + 5'd1;

  function automatic state_t level_state(input logic [3:0] lvl, input logic up);
    if (lvl == 4'd0)      return ST_IDLE;
    else if (lvl == 4'd8) return ST_FULL;
    else if (up)          return ST_UP;
    else                  return ST_DOWN;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_reg    <= 8'd0;
      s2_reg    <= 8'd0;
      state_reg <= ST_IDLE;
      level_reg <= 4'd0;
      delay_reg <= 5'd0;
      cnt_reg   <= 5'd0;
      step_reg  <= 1'b0;
      dir_reg   <= 1'b0;
      fault_reg <= 1'b0;
    end else begin
      s1_reg    <= channel_in;
      s2_reg    <= s1_reg;
      state_reg <= state_next;
      level_reg <= level_next;
      delay_reg <= delay_next;
      cnt_reg   <= cnt_next;
      step_reg  <= step_next;
      dir_reg   <= dir_next;
      fault_reg <= fault_next;
    end
  end

  // Clear wins over everything; FAULT freezes all but the free-running counter.
  always_comb begin
    state_next = state_reg;
    level_next = level_reg;
    delay_next = delay_reg;
    cnt_next   = cnt_inc;
    step_next  = 1'b0;
    dir_next   = dir_reg;
    fault_next = fault_reg;
    if (clear) begin
      fault_next = 1'b0;
      cnt_next   = 5'd0;
      delay_next = 5'd0;
      dir_next   = 1'b0;
      level_next = code_valid ? code_level : 4'd0;
      state_next = level_state(level_next, 1'b1);
    end else if (state_reg == ST_FAULT) begin
      state_next = ST_FAULT;
    end else if (is_up || is_down) begin
      step_next  = 1'b1;
      dir_next   = is_up;
      level_next = code_level;
      delay_next = cnt_reg;
      cnt_next   = 5'd0;
      state_next = level_state(code_level, is_up);
    end else if (!is_hold) begin
      fault_next = 1'b1;
      state_next = ST_FAULT;
    end
  end

  assign level          = level_reg;
  assign measured_delay = delay_reg;
  assign step           = step_reg;
  assign dir            = dir_reg;
  assign fault          = fault_reg;
  assign state          = state_reg;

endmodule
